// File: rtl/simmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simmem_pkg                                                           |
// | Shared defaults and owed-burst entry type for the write-data tracker |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package simmem_pkg;

  localparam int unsigned DefIidW          = 4;
  localparam int unsigned DefBurstLenW     = 8;
  localparam int unsigned DefOwedDepth     = 8;
  localparam int unsigned DefMaxEarlyBeats = 256;

  // remaining is one bit wider than AxLEN so a full 2^BurstLenW-beat burst fits
  typedef struct packed {
    logic [DefIidW-1:0]    iid;
    logic [DefBurstLenW:0] remaining;
  } owed_entry_t;

endpackage : simmem_pkg
`default_nettype wire

// File: rtl/simmem_wdata_owed_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simmem_wdata_owed_fifo                                               |
// | Circular FIFO of owed bursts with in-place head remaining decrement  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module simmem_wdata_owed_fifo
  import simmem_pkg::*;
#(
  parameter int unsigned DEPTH = DefOwedDepth,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  owed_entry_t     push_entry_i,
  input  logic            pop_i,
  input  logic            dec_i,
  output owed_entry_t     head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned c_rem_w = DefBurstLenW + 1;

  owed_entry_t     r_mem [DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;

  assign head_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == CntW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // push never targets the head slot: the queue is non-full on push and non-empty on dec
      if (push_i) begin
        r_mem[r_wr_ptr] <= push_entry_i;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (pop_i) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end else if (dec_i) begin
        r_mem[r_rd_ptr].remaining <= r_mem[r_rd_ptr].remaining - c_rem_w'(1);
      end
      r_count <= r_count + CntW'(push_i) - CntW'(pop_i);
    end
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni) !((pop_i || dec_i) && empty_o));

endmodule : simmem_wdata_owed_fifo
`default_nettype wire

// File: rtl/simmem_wdata_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | simmem_wdata_tracker                                                 |
// | Matches snooped AXI W beats to AW bursts, tagging owed beats by iid  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module simmem_wdata_tracker
  import simmem_pkg::*;
#(
  parameter int unsigned IidW          = DefIidW,
  parameter int unsigned BurstLenW     = DefBurstLenW,
  parameter int unsigned OwedDepth     = DefOwedDepth,
  parameter int unsigned MaxEarlyBeats = DefMaxEarlyBeats
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 waddr_valid_i,
  output logic                                 waddr_ready_o,
  input  logic [IidW-1:0]                      waddr_iid_i,
  input  logic [BurstLenW-1:0]                 waddr_len_i,
  input  logic                                 wdata_valid_i,
  output logic                                 wdata_ready_o,
  input  logic                                 wdata_last_i,
  output logic                                 burst_valid_o,
  input  logic                                 burst_ready_i,
  output logic [IidW-1:0]                      burst_iid_o,
  output logic [BurstLenW:0]                   burst_imm_cnt_o,
  output logic                                 beat_valid_o,
  output logic [IidW-1:0]                      beat_iid_o,
  output logic                                 beat_last_o,
  output logic [$clog2(MaxEarlyBeats+1)-1:0]   early_cnt_o,
  output logic [$clog2(OwedDepth+1)-1:0]       owed_cnt_o,
  output logic                                 err_wlast_o
);

  localparam int unsigned c_early_w = $clog2(MaxEarlyBeats + 1);
  localparam int unsigned c_len_w   = BurstLenW + 1;

  logic [c_early_w-1:0] r_early;
  logic [c_early_w-1:0] w_early_d;
  logic [c_early_w-1:0] w_early_nxt;
  logic [c_early_w-1:0] w_beats_ext;
  logic [c_len_w-1:0]   w_beats;
  logic [c_len_w-1:0]   w_imm;
  logic                 r_err;
  owed_entry_t          w_head;
  owed_entry_t          w_push_entry;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_beat_acc;
  logic                 w_early_beat;
  logic                 w_addr_acc;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_head_last;

  // Data side: beats go to the oldest owed burst, otherwise they are counted as early
  assign wdata_ready_o = rst_ni && !(w_empty && (r_early == c_early_w'(MaxEarlyBeats)));
  assign w_beat_acc    = wdata_valid_i && wdata_ready_o;
  assign w_head_last   = (w_head.remaining == c_len_w'(1));
  assign beat_valid_o  = w_beat_acc && !w_empty;
  assign beat_iid_o    = w_head.iid;
  assign beat_last_o   = beat_valid_o && w_head_last;
  assign w_early_beat  = w_beat_acc && w_empty;
  assign w_early_d     = r_early + c_early_w'(w_early_beat);
  assign w_pop         = beat_valid_o && w_head_last;

  // Address side: a slot freed by this cycle's pop is only offered next cycle
  assign burst_valid_o   = rst_ni && waddr_valid_i && !w_full;
  assign waddr_ready_o   = rst_ni && burst_ready_i && !w_full;
  assign w_addr_acc      = waddr_valid_i && waddr_ready_o;
  assign burst_iid_o     = waddr_iid_i;
  assign w_beats         = c_len_w'(waddr_len_i) + c_len_w'(1);
  assign w_beats_ext     = c_early_w'(w_beats);
  assign w_imm           = (w_early_d < w_beats_ext) ? w_early_d[c_len_w-1:0] : w_beats;
  assign burst_imm_cnt_o = w_imm;
  assign w_early_nxt     = w_addr_acc ? (w_early_d - c_early_w'(w_imm)) : w_early_d;
  assign w_push          = w_addr_acc && (w_imm != w_beats);

  always_comb begin
    w_push_entry           = '0;
    w_push_entry.iid       = waddr_iid_i;
    w_push_entry.remaining = w_beats - w_imm;
  end

  simmem_wdata_owed_fifo #(
    .DEPTH (OwedDepth)
  ) u_owed_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .dec_i        (beat_valid_o),
    .head_o       (w_head),
    .full_o       (w_full),
    .empty_o      (w_empty),
    .count_o      (owed_cnt_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_early <= '0;
      r_err   <= 1'b0;
    end else begin
      r_early <= w_early_nxt;
      if (beat_valid_o && (wdata_last_i != beat_last_o)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign early_cnt_o = r_early;
  assign err_wlast_o = r_err;

  a_early_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_early <= c_early_w'(MaxEarlyBeats));

endmodule : simmem_wdata_tracker
`default_nettype wire

// File: tb/tb_simmem_wdata_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_simmem_wdata_tracker                                              |
// | Directed self-checking bench for simmem_wdata_tracker               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_simmem_wdata_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       waddr_valid_i;
  logic       waddr_ready_o;
  logic [3:0] waddr_iid_i;
  logic [7:0] waddr_len_i;
  logic       wdata_valid_i;
  logic       wdata_ready_o;
  logic       wdata_last_i;
  logic       burst_valid_o;
  logic       burst_ready_i;
  logic [3:0] burst_iid_o;
  logic [8:0] burst_imm_cnt_o;
  logic       beat_valid_o;
  logic [3:0] beat_iid_o;
  logic       beat_last_o;
  logic [8:0] early_cnt_o;
  logic [3:0] owed_cnt_o;
  logic       err_wlast_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  simmem_wdata_tracker dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .waddr_valid_i   (waddr_valid_i),
    .waddr_ready_o   (waddr_ready_o),
    .waddr_iid_i     (waddr_iid_i),
    .waddr_len_i     (waddr_len_i),
    .wdata_valid_i   (wdata_valid_i),
    .wdata_ready_o   (wdata_ready_o),
    .wdata_last_i    (wdata_last_i),
    .burst_valid_o   (burst_valid_o),
    .burst_ready_i   (burst_ready_i),
    .burst_iid_o     (burst_iid_o),
    .burst_imm_cnt_o (burst_imm_cnt_o),
    .beat_valid_o    (beat_valid_o),
    .beat_iid_o      (beat_iid_o),
    .beat_last_o     (beat_last_o),
    .early_cnt_o     (early_cnt_o),
    .owed_cnt_o      (owed_cnt_o),
    .err_wlast_o     (err_wlast_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // advance past the next rising edge; inputs and checks happen mid-cycle
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    waddr_valid_i = 1'b0;
    wdata_valid_i = 1'b0;
    wdata_last_i  = 1'b0;
    waddr_iid_i   = '0;
    waddr_len_i   = '0;
    burst_ready_i = 1'b1;
  endtask

  task automatic addr(input logic [3:0] iid, input logic [7:0] len);
    waddr_valid_i = 1'b1;
    waddr_iid_i   = iid;
    waddr_len_i   = len;
  endtask

  task automatic beat(input logic last);
    wdata_valid_i = 1'b1;
    wdata_last_i  = last;
  endtask

  initial begin
    logic [2:0] t3_last;
    logic [2:0] t3_exp_last;
    logic [3:0] t3_exp_iid [3];
    t3_last        = 3'b110;
    t3_exp_last    = 3'b110;
    t3_exp_iid[0]  = 4'd1;
    t3_exp_iid[1]  = 4'd1;
    t3_exp_iid[2]  = 4'd2;

    idle();
    rst_ni = 1'b0;
    waddr_valid_i = 1'b1;
    wdata_valid_i = 1'b1;
    tick();
    tick();
    check_eq("rst_waddr_ready", waddr_ready_o, 0);
    check_eq("rst_wdata_ready", wdata_ready_o, 0);
    check_eq("rst_burst_valid", burst_valid_o, 0);
    check_eq("rst_beat_valid", beat_valid_o, 0);
    idle();
    rst_ni = 1'b1;
    #1;
    check_eq("rst_early", early_cnt_o, 0);
    check_eq("rst_owed", owed_cnt_o, 0);
    check_eq("rst_err", err_wlast_o, 0);
    check_eq("rst_wdata_ready_after", wdata_ready_o, 1);

    // 1: early beats then address
    beat(1'b0);
    #1;
    check_eq("t1_early_no_beat", beat_valid_o, 0);
    tick(); tick(); tick();
    idle();
    #1;
    check_eq("t1_early3", early_cnt_o, 3);
    addr(4'd5, 8'd3);
    #1;
    check_eq("t1_burst_valid", burst_valid_o, 1);
    check_eq("t1_burst_iid", burst_iid_o, 5);
    check_eq("t1_imm", burst_imm_cnt_o, 3);
    tick();
    idle();
    #1;
    check_eq("t1_owed1", owed_cnt_o, 1);
    check_eq("t1_early0", early_cnt_o, 0);
    beat(1'b1);
    #1;
    check_eq("t1_beat_valid", beat_valid_o, 1);
    check_eq("t1_beat_iid", beat_iid_o, 5);
    check_eq("t1_beat_last", beat_last_o, 1);
    tick();
    idle();
    #1;
    check_eq("t1_owed0", owed_cnt_o, 0);
    check_eq("t1_early_end", early_cnt_o, 0);
    check_eq("t1_err", err_wlast_o, 0);

    // 2: same-cycle beat and single-beat address with empty queue
    beat(1'b1);
    addr(4'd2, 8'd0);
    #1;
    check_eq("t2_imm", burst_imm_cnt_o, 1);
    check_eq("t2_beat_valid", beat_valid_o, 0);
    tick();
    idle();
    #1;
    check_eq("t2_owed", owed_cnt_o, 0);
    check_eq("t2_early", early_cnt_o, 0);

    // 3: two owed bursts then three beats
    addr(4'd1, 8'd1);
    #1;
    check_eq("t3_imm0", burst_imm_cnt_o, 0);
    tick();
    addr(4'd2, 8'd0);
    tick();
    idle();
    #1;
    check_eq("t3_owed2", owed_cnt_o, 2);
    for (int i = 0; i < 3; i++) begin
      beat(t3_last[i]);
      #1;
      check_eq($sformatf("t3_beat%0d_valid", i), beat_valid_o, 1);
      check_eq($sformatf("t3_beat%0d_iid", i), beat_iid_o, 32'(t3_exp_iid[i]));
      check_eq($sformatf("t3_beat%0d_last", i), beat_last_o, 32'(t3_exp_last[i]));
      tick();
    end
    idle();
    #1;
    check_eq("t3_owed0", owed_cnt_o, 0);
    check_eq("t3_err", err_wlast_o, 0);

    // 4: early counter saturation and full drain by a 256-beat burst
    beat(1'b0);
    for (int i = 0; i < 256; i++) tick();
    idle();
    #1;
    check_eq("t4_early256", early_cnt_o, 256);
    check_eq("t4_wdata_ready0", wdata_ready_o, 0);
    addr(4'd3, 8'd255);
    #1;
    check_eq("t4_waddr_ready", waddr_ready_o, 1);
    check_eq("t4_imm256", burst_imm_cnt_o, 256);
    tick();
    idle();
    #1;
    check_eq("t4_early0", early_cnt_o, 0);
    check_eq("t4_wdata_ready1", wdata_ready_o, 1);
    check_eq("t4_owed0", owed_cnt_o, 0);

    // 5: owed queue full backpressure
    for (int i = 0; i < 8; i++) begin
      addr(4'(i), 8'd0);
      tick();
    end
    idle();
    addr(4'd9, 8'd0);
    #1;
    check_eq("t5_owed8", owed_cnt_o, 8);
    check_eq("t5_full_waddr_ready", waddr_ready_o, 0);
    check_eq("t5_full_burst_valid", burst_valid_o, 0);
    beat(1'b1);
    #1;
    check_eq("t5_pop_beat_iid", beat_iid_o, 0);
    check_eq("t5_pop_same_cycle_ready", waddr_ready_o, 0);
    tick();
    idle();
    #1;
    check_eq("t5_owed7", owed_cnt_o, 7);
    check_eq("t5_ready_back", waddr_ready_o, 1);
    burst_ready_i = 1'b0;
    addr(4'd9, 8'd0);
    #1;
    check_eq("t5_nr_burst_valid", burst_valid_o, 1);
    check_eq("t5_nr_waddr_ready", waddr_ready_o, 0);
    tick();
    idle();
    #1;
    check_eq("t5_nr_owed7", owed_cnt_o, 7);
    beat(1'b1);
    for (int i = 0; i < 7; i++) tick();
    idle();
    #1;
    check_eq("t5_drained", owed_cnt_o, 0);
    check_eq("t5_err", err_wlast_o, 0);

    // 6: WLAST mismatch is sticky; mid-burst reset discards everything
    addr(4'd9, 8'd1);
    tick();
    idle();
    beat(1'b1);
    #1;
    check_eq("t6_beat_valid", beat_valid_o, 1);
    check_eq("t6_beat_last0", beat_last_o, 0);
    tick();
    idle();
    #1;
    check_eq("t6_err_set", err_wlast_o, 1);
    check_eq("t6_owed1", owed_cnt_o, 1);
    tick();
    check_eq("t6_err_sticky", err_wlast_o, 1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    check_eq("t6_rst_err", err_wlast_o, 0);
    check_eq("t6_rst_early", early_cnt_o, 0);
    check_eq("t6_rst_owed", owed_cnt_o, 0);
    beat(1'b1);
    #1;
    check_eq("t6_no_stale_beat", beat_valid_o, 0);
    tick();
    idle();
    #1;
    check_eq("t6_early1", early_cnt_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_simmem_wdata_tracker
`default_nettype wire
